// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM demultiplexer.
// Holds the framing state enum and lane-counter width function.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_LANES = 4;
    localparam int DEF_WIDTH = 1;

    // Lane counter must also reach LANES (parity slot).
    function automatic int lane_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdm_demux_1_4_low_demux.sv
// 1:2 enable steering cell; one node of the shadow write tree.
// Routes data and enable to the output picked by sel.
module low_demux
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             e0,
    output logic             e1
);

    assign e0 = en & ~sel;
    assign e1 = en & sel;
    assign y0 = e0 ? d : '0;
    assign y1 = e1 ? d : '0;

endmodule

// File: rtl/tdm_demux_1_4.sv
// Frame-aligned 1:LANES TDM demultiplexer with atomic frame commit.
// Define TDM_DEMUX_PARITY_EN to add an even-parity slot per frame.
module tdm_demux_1_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
) (
    input  logic                     CLOCK_50,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     sync,
    output logic [LANES*WIDTH-1:0]   dout,
    output logic                     dout_valid,
    output logic [lane_w(LANES)-1:0] lane,
    output logic                     locked,
    output logic                     err
);

    localparam int LW = lane_w(LANES);
    localparam int D  = $clog2(LANES);
    localparam int N  = 1 << D;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    state_t state, state_nxt;

    logic             wr_en;
    logic             commit;
    logic             fault;
    logic [LW-1:0]    lane_nxt;
    logic [D-1:0]     widx;
    logic [WIDTH-1:0] shadow [LANES];

    logic [LANES*WIDTH-1:0] shadow_flat;
    logic [LANES*WIDTH-1:0] commit_data;

    logic             t_en [2*N-1];
    logic [WIDTH-1:0] t_d  [2*N-1];

    always_ff @(posedge CLOCK_50) begin
        if (RST) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HUNT:
                if (din_valid && sync)
                    state_nxt = LOCKED;
            LOCKED:
                if (din_valid && !sync && lane == '0)
                    state_nxt = HUNT;
        endcase
    end

    always_comb begin
        locked   = (state == LOCKED);
        wr_en    = 1'b0;
        commit   = 1'b0;
        fault    = 1'b0;
        lane_nxt = lane;
        if (din_valid) begin
            if (sync) begin
                wr_en    = 1'b1;
                lane_nxt = LW'(1);
                fault    = locked && (lane != '0);
            end else if (locked) begin
                if (lane == '0) begin
                    fault = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                end else if (lane == LW'(LANES)) begin
                    lane_nxt = '0;
                    if ((^shadow_flat) == din[0])
                        commit = 1'b1;
                    else
                        fault = 1'b1;
                end else if (lane == LAST) begin
                    wr_en    = 1'b1;
                    lane_nxt = LW'(LANES);
`else
                end else if (lane == LAST) begin
                    wr_en    = 1'b1;
                    commit   = 1'b1;
                    lane_nxt = '0;
`endif
                end else begin
                    wr_en    = 1'b1;
                    lane_nxt = lane + 1'b1;
                end
            end
        end
    end

    // A sync beat always lands in slot 0, whatever lane says.
    assign widx    = sync ? '0 : lane[D-1:0];
    assign t_en[0] = wr_en;
    assign t_d[0]  = din;

    for (genvar l = 0; l < D; l++) begin : g_lvl
        for (genvar j = 0; j < (1 << l); j++) begin : g_node
            localparam int NI = (1 << l) - 1 + j;
            low_demux #(.WIDTH(WIDTH)) u_node (
                .d   (t_d[NI]),
                .sel (widx[D-1-l]),
                .en  (t_en[NI]),
                .y0  (t_d[2*NI+1]),
                .y1  (t_d[2*NI+2]),
                .e0  (t_en[2*NI+1]),
                .e1  (t_en[2*NI+2])
            );
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_frame
        assign shadow_flat[k*WIDTH +: WIDTH] = shadow[k];
`ifndef TDM_DEMUX_PARITY_EN
        assign commit_data[k*WIDTH +: WIDTH] =
            t_en[N-1+k] ? t_d[N-1+k] : shadow[k];
`endif
    end

`ifdef TDM_DEMUX_PARITY_EN
    assign commit_data = shadow_flat;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            lane       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            for (int k = 0; k < LANES; k++)
                shadow[k] <= '0;
        end else begin
            lane       <= lane_nxt;
            dout_valid <= commit;
            err        <= fault;
            if (commit)
                dout <= commit_data;
            for (int k = 0; k < LANES; k++)
                if (t_en[N-1+k])
                    shadow[k] <= t_d[N-1+k];
        end
    end

endmodule
